serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial two's-complement subtractor, the inverse operation to the team's 1-bit full-adder cell. It computes DIFF = A - B one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It reports borrow-out, signed overflow and zero flags. It sits beside the adder in the lab ALU datapath as the low-area subtract path, using a start/busy/done handshake.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 1..32)

Ports:
clk  input  1  rising-edge clock; the only clock
rst_n  input  1  synchronous active-low reset; sampled on the rising edge of clk
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend; captured in the start cycle
b  input  WIDTH  subtrahend; captured in the start cycle
busy  output  1  high while the operation is in progress (SHIFT state)
done  output  1  one-cycle pulse; result and flags valid from this cycle on
diff  output  WIDTH  A - B modulo 2^WIDTH
bout  output  1  final borrow; 1 iff unsigned A < B
ovf  output  1  signed overflow: a_msb != b_msb and diff_msb != a_msb
zero  output  1  1 iff diff == 0

Behaviour:
- Reset (rst_n==0 at a clk edge): state=IDLE. busy, done, diff, bout, ovf and zero are all 0. Shift registers, borrow FF and counter are cleared. Reset overrides every other input.
- Reset mid-operation aborts the operation. No done pulse is produced. Outputs read 0 in the following cycle.
- States: IDLE, SHIFT, DONE. Binary encoding, 2 bits.
- IDLE, start==1: load a_sr<=a, b_sr<=b, res_sr<=0, brw<=0, cnt<=0, a_msb<=a[WIDTH-1], b_msb<=b[WIDTH-1]; go to SHIFT. Captured operands are immune to later changes on a and b.
- IDLE, start==0: hold. diff and flags keep the last result.
- SHIFT, every cycle:
  - d = a_sr[0]^b_sr[0]^brw
  - brw <= (~a_sr[0]&b_sr[0]) | (~(a_sr[0]^b_sr[0])&brw)
  - a_sr and b_sr shift right by 1
  - res_sr <= {d, res_sr[WIDTH-1:1]}
  - cnt++
  - when cnt==WIDTH-1, go to DONE
- DONE (exactly one cycle): done=1. diff=res_sr, bout=brw, ovf per the formula above, zero=(res_sr==0). Then go to IDLE.
- diff, bout, ovf and zero are registered. They update on entry to DONE and hold until the next DONE or reset.
- Latency: start sampled at edge 0 -> busy high in cycles 1..WIDTH -> done high in cycle WIDTH+1. Throughput is one operation per WIDTH+2 cycles.
- start is ignored while in SHIFT or DONE. No queuing; the requester must wait for done.
- start held high continuously: a new operation begins on the first IDLE cycle after DONE.
- cnt width is clog2(WIDTH)+1. For WIDTH=1, SHIFT lasts exactly one cycle.
- busy = (state==SHIFT). busy and done are never high together.

Decomposition:
- Shared package alu_pkg: state encodings S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2; default width constant ALU_W=8.
- One sub-module, full_sub_bit: combinational 1-bit full subtractor with inputs (x, y, bin) and outputs (d, bout). Gate-level, mirroring the full-adder cell.
- The top level holds the FSM, counter, shift registers, borrow FF and flag logic.

Test Plan:
- WIDTH=8, a=100, b=37, start pulse -> done in cycle 9; diff=63 (0x3F), bout=0, ovf=0, zero=0; busy high for exactly cycles 1..8.
- a=37, b=100 -> diff=0xC1 (193), bout=1, ovf=0, zero=0.
- a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1. Then a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
- a=55, b=55 -> diff=0, zero=1, bout=0, ovf=0. Change a and b during SHIFT -> result unchanged.
- Pulse start again in cycle 3 of an operation -> ignored, exactly one done. Hold start high -> back-to-back operations with done every 10 cycles.
- rst_n=0 in cycle 4 of an operation -> no done pulse; all outputs 0 next cycle; a fresh start afterwards yields the correct result.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared constants and state encodings for the lab ALU datapath.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/full_sub_bit.sv
`default_nettype none
// ============================================================================
// Module   : full_sub_bit
// Brief    : Gate-level 1-bit full subtractor, x - y - bin.
// Revision : 1.0 - initial release
// ============================================================================
module full_sub_bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic w_xy;

    assign w_xy = x ^ y;
    assign d    = w_xy ^ bin;
    // Borrow when y exceeds x, or when they match and a borrow ripples through.
    assign bout = (~x & y) | (~w_xy & bin);

endmodule : full_sub_bit
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial two's-complement subtractor (A - B), LSB first, with
//            start/busy/done handshake and borrow/overflow/zero flags.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int                c_cnt_w = $clog2(WIDTH) + 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_res_sr;
    logic               r_brw;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_a_msb;
    logic               r_b_msb;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
    logic               r_ovf;
    logic               r_zero;

    logic               w_d;
    logic               w_brw_nxt;
    logic [WIDTH-1:0]   w_res_nxt;

    full_sub_bit u_cell (
        .x    (r_a_sr[0]),
        .y    (r_b_sr[0]),
        .bin  (r_brw),
        .d    (w_d),
        .bout (w_brw_nxt)
    );

    // Concatenate-then-shift keeps the insert-at-MSB form legal for WIDTH=1.
    assign w_res_nxt = WIDTH'({w_d, r_res_sr} >> 1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_SHIFT;
            S_SHIFT: if (r_cnt == c_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_res_sr <= '0;
            r_brw    <= 1'b0;
            r_cnt    <= '0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sr   <= a;
                        r_b_sr   <= b;
                        r_res_sr <= '0;
                        r_brw    <= 1'b0;
                        r_cnt    <= '0;
                        r_a_msb  <= a[WIDTH-1];
                        r_b_msb  <= b[WIDTH-1];
                    end
                end
                S_SHIFT: begin
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_res_sr <= w_res_nxt;
                    r_brw    <= w_brw_nxt;
                    r_cnt    <= r_cnt + 1'b1;
                    // Flags are captured from the final-bit values so they are
                    // already valid in the DONE cycle.
                    if (r_cnt == c_last) begin
                        r_diff <= w_res_nxt;
                        r_bout <= w_brw_nxt;
                        r_ovf  <= (r_a_msb != r_b_msb) && (w_res_nxt[WIDTH-1] != r_a_msb);
                        r_zero <= (w_res_nxt == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == S_SHIFT);
    assign done = (r_state == S_DONE);
    assign diff = r_diff;
    assign bout = r_bout;
    assign ovf  = r_ovf;
    assign zero = r_zero;

endmodule : serial_subtractor
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Brief    : Directed self-checking bench for serial_subtractor (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;

    int n_tests = 0;
    int n_fail  = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf),
        .zero  (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Launch one operation and follow it until done (bounded). Cycle k is the
    // k-th cycle after the edge that samples start.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                          input int pert_k, output int done_k, output int busy_n,
                          output int overlap);
        @(negedge clk);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        @(posedge clk);
        done_k  = -1;
        busy_n  = 0;
        overlap = 0;
        for (int k = 1; k <= 20 && done_k < 0; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == pert_k) begin
                a = ~ta;
                b = ta ^ 8'h5A;
            end
            if (busy) busy_n++;
            if (busy && done) overlap++;
            if (done) done_k = k;
        end
    endtask

    task automatic check_result(input string tag, input logic [7:0] e_diff,
                                input logic e_bout, input logic e_ovf, input logic e_zero);
        check({tag, ".diff"}, 32'(diff), 32'(e_diff));
        check({tag, ".bout"}, 32'(bout), 32'(e_bout));
        check({tag, ".ovf"},  32'(ovf),  32'(e_ovf));
        check({tag, ".zero"}, 32'(zero), 32'(e_zero));
    endtask

    int dk, bn, ov, ndone, first_k, last_k;

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        check("rst.outs", 32'({busy, done, bout, ovf, zero}), 32'd0);
        check("rst.diff", 32'(diff), 32'd0);
        rst_n = 1'b1;

        // 100 - 37 = 63
        run_op(8'd100, 8'd37, 0, dk, bn, ov);
        check("op1.done_cycle", 32'(dk), 32'd9);
        check("op1.busy_cycles", 32'(bn), 32'd8);
        check("op1.overlap", 32'(ov), 32'd0);
        check_result("op1", 8'h3F, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("op1.done_pulse", 32'(done), 32'd0);
        check("op1.hold", 32'(diff), 32'h3F);

        // 37 - 100 = -63
        run_op(8'd37, 8'd100, 0, dk, bn, ov);
        check("op2.done_cycle", 32'(dk), 32'd9);
        check_result("op2", 8'hC1, 1'b1, 1'b0, 1'b0);

        // Signed overflow in both directions
        run_op(8'h80, 8'h01, 0, dk, bn, ov);
        check_result("op3", 8'h7F, 1'b0, 1'b1, 1'b0);
        run_op(8'h7F, 8'hFF, 0, dk, bn, ov);
        check_result("op4", 8'h80, 1'b1, 1'b1, 1'b0);

        // Equal operands, with inputs disturbed mid-operation
        run_op(8'd55, 8'd55, 3, dk, bn, ov);
        check("op5.done_cycle", 32'(dk), 32'd9);
        check_result("op5", 8'h00, 1'b0, 1'b0, 1'b1);

        // Second start pulse during SHIFT must be ignored
        @(negedge clk);
        a = 8'h10; b = 8'h01; start = 1'b1;
        @(posedge clk);
        ndone = 0; first_k = -1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            start = (k == 3);
            if (done) begin
                ndone++;
                if (first_k < 0) first_k = k;
            end
        end
        check("ign.done_count", 32'(ndone), 32'd1);
        check("ign.done_cycle", 32'(first_k), 32'd9);
        check("ign.diff", 32'(diff), 32'h0F);

        // start held high: back-to-back operations every 10 cycles
        @(negedge clk);
        a = 8'd200; b = 8'd50; start = 1'b1;
        @(posedge clk);
        ndone = 0; first_k = -1; last_k = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 30) start = 1'b0;
            if (busy && done) ndone += 100;
            if (done) begin
                ndone++;
                if (first_k < 0) first_k = k;
                last_k = k;
            end
        end
        check("b2b.done_count", 32'(ndone), 32'd3);
        check("b2b.first", 32'(first_k), 32'd9);
        check("b2b.last", 32'(last_k), 32'd29);
        check_result("b2b", 8'h96, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        // Reset in cycle 4 aborts the operation
        a = 8'd9; b = 8'd3; start = 1'b1;
        @(posedge clk);
        ndone = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) ndone++;
            if (k == 4) rst_n = 1'b0;
        end
        check("abort.outs", 32'({busy, done, bout, ovf, zero}), 32'd0);
        check("abort.diff", 32'(diff), 32'd0);
        rst_n = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort.no_done", 32'(ndone), 32'd0);
        run_op(8'd9, 8'd3, 0, dk, bn, ov);
        check("fresh.done_cycle", 32'(dk), 32'd9);
        check_result("fresh", 8'h06, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_serial_subtractor
`default_nettype wire
